// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_pkg
// Brief   : Shared fetch-stage defines, constants and types.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef PC_FETCH_DEFINES
`define PC_FETCH_DEFINES
`define NOP              32'h0000_0013
`define RESET_PC_DEFAULT 32'h0000_0000
`define INST_W           32
`endif

package pc_fetch_pkg;

  localparam int              XLEN             = `INST_W;
  localparam logic [XLEN-1:0] NOP_INST         = `NOP;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = `RESET_PC_DEFAULT;

  // One prefetched instruction together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_if
// Brief   : Instruction-memory request/response bus between fetch and imem.
// Revision: 1.0 - initial release
// ============================================================================

interface pc_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  // Fetch stage side: issues requests, receives in-order responses
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  // Memory side
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Small synchronous FIFO with flush, occupancy count and
//           combinational head output.
// Revision: 1.0 - initial release
// ============================================================================

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             pop_i,
  input  wire logic             flush_i,
  output logic      [WIDTH-1:0] head_o,
  output logic      [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Refuse pushes into a full FIFO and pops from an empty one
  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch
// Brief   : Instruction-fetch stage: PC generation, credit-limited imem
//           requests, prefetch FIFO feeding IF/ID, hold and jump redirect
//           with discard of stale in-flight responses.
// Revision: 1.0 - initial release
// ============================================================================

module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        jump_en_i,
  input  wire logic [31:0] jump_addr_i,
  input  wire logic        hold_i,
  pc_fetch_if.master       imem,
  output logic             valid_o,
  output logic      [31:0] Inst_o,
  output logic      [31:0] PC_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] inflight;       // tag-queue occupancy == requests outstanding
  logic [CW-1:0] inflight_d;
  logic [CW-1:0] inst_count;
  logic [CW:0]   credit_used;
  logic [31:0]   tag_head;
  fetch_entry_t  inst_head;
  fetch_entry_t  inst_wdata;
  logic          issue;
  logic          resp;
  logic          push_inst;
  logic          pop_inst;

  // Issue/response/pop decisions and next-state of PC and drop counter
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, inst_count};
    // Gate on rst_n so no request is visible while reset is held
    issue       = rst_n && !jump_en_i && (credit_used < (CW+1)'(DEPTH));
    resp        = imem.imem_rvalid_i && (inflight != '0);
    // A response landing in a jump cycle is stale as well
    push_inst   = resp && (drop_q == '0) && !jump_en_i;
    valid_o     = (inst_count != '0) && !jump_en_i;
    pop_inst    = valid_o && !hold_i;
    inflight_d  = inflight + CW'(issue) - CW'(resp);

    drop_d = drop_q;
    if (jump_en_i) begin
      drop_d = inflight_d;
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (jump_en_i) begin
      fetch_pc_d = word_align(jump_addr_i);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    inst_wdata.pc   = tag_head;
    inst_wdata.inst = imem.imem_rdata_i;

    Inst_o = valid_o ? inst_head.inst : NOP_INST;
    PC_o   = valid_o ? inst_head.pc   : 32'h0;
  end

  // Fetch PC and stale-response counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign imem.imem_req_o  = issue;
  assign imem.imem_addr_o = fetch_pc_q;

  // PCs of outstanding requests, consumed as responses come back in order
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue),
    .data_i  (fetch_pc_q),
    .pop_i   (resp),
    .flush_i (1'b0),
    .head_o  (tag_head),
    .count_o (inflight)
  );

  // Prefetched {pc, inst} entries presented to IF/ID
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_inst),
    .data_i  (inst_wdata),
    .pop_i   (pop_inst),
    .flush_i (jump_en_i),
    .head_o  (inst_head),
    .count_o (inst_count)
  );

  // A response with nothing outstanding is a memory-side protocol error
  a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst_n)
    imem.imem_rvalid_i |-> (inflight != '0));

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch
// Brief   : Self-checking bench for pc_fetch: directed vector table, directed
//           jump/hold/reset sequences and randomized traffic against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================

module tb_pc_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;

  pc_fetch_if imem ();

  pc_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_en_i   (jump_en),
    .jump_addr_i (jump_addr),
    .hold_i      (hold),
    .imem        (imem),
    .valid_o     (valid),
    .Inst_o      (inst),
    .PC_o        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (queues) ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_tags[$];
  ent_t        m_fifo[$];
  int          m_drop;
  logic [31:0] memq[$];

  task automatic model_reset();
    m_pc   = RST_PC;
    m_tags.delete();
    m_fifo.delete();
    m_drop = 0;
    memq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: called just after a rising edge; drives inputs,
  // checks outputs at the falling edge, advances model at the next rise.
  task automatic step(input bit j, input logic [31:0] ja, input bit h, input int resp_pct,
                      output bit o_req, output logic [31:0] o_addr,
                      output bit o_valid, output logic [31:0] o_pc);
    bit          e_valid, e_req, rv;
    logic [31:0] rd, t;
    jump_en = j; jump_addr = ja; hold = h;
    rv = (memq.size() > 0) && (int'($urandom_range(0, 99)) < resp_pct);
    rd = rv ? memq[0] : 32'h0;
    imem.imem_rvalid_i = rv;
    imem.imem_rdata_i  = rd;
    @(negedge clk);
    e_valid = (m_fifo.size() > 0) && !j;
    e_req   = !j && ((m_tags.size() + m_fifo.size()) < DEPTH);
    check("req",   32'(imem.imem_req_o), 32'(e_req));
    check("addr",  imem.imem_addr_o, m_pc);
    check("valid", 32'(valid), 32'(e_valid));
    check("pc",    pc,   e_valid ? m_fifo[0].pc   : 32'h0);
    check("inst",  inst, e_valid ? m_fifo[0].inst : NOP);
    check("fifo_bound", 32'(u_dut.inst_count <= DEPTH), 32'd1);
    o_req = imem.imem_req_o; o_addr = imem.imem_addr_o;
    o_valid = valid; o_pc = pc;
    @(posedge clk);
    if (e_valid && !h) void'(m_fifo.pop_front());
    if (rv && m_tags.size() > 0) begin
      t = m_tags.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!j) m_fifo.push_back('{pc: t, inst: rd});
    end
    if (e_req) begin
      m_tags.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (j) begin
      m_fifo.delete();
      m_pc   = {ja[31:2], 2'b00};
      m_drop = m_tags.size();   // everything still outstanding is stale
    end
    if (rv) void'(memq.pop_front());
    if (o_req) memq.push_back(o_addr);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          hold;
    bit          jump;
    logic [31:0] jaddr;
    bit          rvalid;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(bit h, bit j, logic [31:0] ja, bit rv, logic [31:0] rd,
                              bit er, logic [31:0] ea, bit ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.hold = h; v.jump = j; v.jaddr = ja; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_req, r_valid, found;
    logic [31:0] r_addr, r_pc;

    // 1-cycle memory returning address as data, then a jump to 0x203
    // and a hold with the FIFO full
    tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h000, 0, 32'h0,   NOP);
    tbl[1]  = mk(0, 0, 32'h0,   1, 32'h0,   1, 32'h004, 0, 32'h0,   NOP);
    tbl[2]  = mk(0, 0, 32'h0,   1, 32'h4,   0, 32'h008, 1, 32'h0,   32'h0);
    tbl[3]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h008, 1, 32'h4,   32'h4);
    tbl[4]  = mk(0, 0, 32'h0,   1, 32'h8,   1, 32'h00c, 0, 32'h0,   NOP);
    tbl[5]  = mk(0, 0, 32'h0,   1, 32'hc,   0, 32'h010, 1, 32'h8,   32'h8);
    tbl[6]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 1, 32'hc,   32'hc);
    tbl[7]  = mk(0, 1, 32'h203, 1, 32'h10,  0, 32'h014, 0, 32'h0,   NOP);
    tbl[8]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,   NOP);
    tbl[9]  = mk(0, 0, 32'h0,   1, 32'h200, 1, 32'h204, 0, 32'h0,   NOP);
    tbl[10] = mk(1, 0, 32'h0,   1, 32'h204, 0, 32'h208, 1, 32'h200, 32'h200);
    tbl[11] = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h208, 1, 32'h200, 32'h200);
    tbl[12] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h208, 1, 32'h200, 32'h200);
    tbl[13] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h208, 1, 32'h204, 32'h204);

    rst_n = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = 32'h0;
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst",  inst, NOP);
    check("rst_pc",    pc, 32'h0);
    check("rst_req",   32'(imem.imem_req_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      hold = tbl[i].hold; jump_en = tbl[i].jump; jump_addr = tbl[i].jaddr;
      imem.imem_rvalid_i = tbl[i].rvalid; imem.imem_rdata_i = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("tbl%0d_req", i),   32'(imem.imem_req_o), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_addr", i),  imem.imem_addr_o, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_pc", i),    pc, tbl[i].e_pc);
      check($sformatf("tbl%0d_inst", i),  inst, tbl[i].e_inst);
      @(posedge clk); #1;
    end

    // Jump to 0x100 with two requests outstanding
    do_reset();
    repeat (2) step(0, 32'h0, 0, 0, r_req, r_addr, r_valid, r_pc);
    step(1, 32'h100, 0, 0, r_req, r_addr, r_valid, r_pc);
    check("jump_cycle_valid", 32'(r_valid), 32'd0);
    check("jump_cycle_req",   32'(r_req), 32'd0);
    step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);
    check("jump_target_addr", r_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);
      found = r_valid;
    end
    if (found) check("jump_first_pc", r_pc, 32'h100);
    else       check("jump_timeout", 32'd0, 32'd1);

    // Hold for several cycles with the FIFO full, then release
    do_reset();
    repeat (3) step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);
    repeat (4) step(0, 32'h0, 1, 100, r_req, r_addr, r_valid, r_pc);
    repeat (6) step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);

    // Asynchronous reset mid-stream with two outstanding, late response in reset
    do_reset();
    repeat (2) step(0, 32'h0, 0, 0, r_req, r_addr, r_valid, r_pc);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_inst",  inst, NOP);
    check("midrst_pc",    pc, 32'h0);
    check("midrst_req",   32'(imem.imem_req_o), 32'd0);
    imem.imem_rvalid_i = 1'b1; imem.imem_rdata_i = 32'hdead_beef;
    @(posedge clk); #1;
    imem.imem_rvalid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);
    check("midrst_restart_addr", r_addr, RST_PC);
    repeat (5) step(0, 32'h0, 0, 100, r_req, r_addr, r_valid, r_pc);

    // Randomized traffic: holds, jumps, variable memory latency
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 2) == 0,
           (n < 500) ? 60 : 90, r_req, r_addr, r_valid, r_pc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
